// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder behind an output register plus skid register.
// Optional feature: define IMM_GEN_TARGET_EN to compute target = pc + imm for B/J/U formats.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int TYPE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm,
    output logic [TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]   target
);
    localparam logic [TYPE_W-1:0] T_NONE = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] T_I    = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_S    = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_B    = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] T_U    = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] T_J    = TYPE_W'(5);

    typedef struct packed {
        logic [XLEN-1:0]   imm;
        logic [TYPE_W-1:0] ty;
        logic [XLEN-1:0]   tgt;
    } ent_t;

    logic [4:0]  op;
    logic [31:0] raw;
    ent_t        dec, or_d, sr_d;
    logic        or_v, sr_v, xin;

    assign op  = inst[6:2];
    assign xin = in_valid && !sr_v;

    // Decode format and build the 32-bit sign-extended immediate, then widen to XLEN.
    always_comb begin
        dec.ty = (op == 5'b00000 || op == 5'b00100 || op == 5'b11001) ? T_I :
                 (op == 5'b01000) ? T_S :
                 (op == 5'b11000) ? T_B :
                 (op == 5'b11011) ? T_J :
                 (op == 5'b01101 || op == 5'b00101) ? T_U : T_NONE;
        raw = (dec.ty == T_I) ? {{20{inst[31]}}, inst[31:20]} :
              (dec.ty == T_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
              (dec.ty == T_B) ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
              (dec.ty == T_J) ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
              (dec.ty == T_U) ? {inst[31:12], 12'b0} : 32'b0;
        dec.imm = XLEN'($signed(raw));
`ifdef IMM_GEN_TARGET_EN
        dec.tgt = (dec.ty == T_B || dec.ty == T_J || dec.ty == T_U) ? pc + dec.imm : '0;
`else
        dec.tgt = '0;
`endif
    end

    // Output register refills from skid first, else from input; skid catches input while output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_v <= 1'b0;
            sr_v <= 1'b0;
            or_d <= '0;
            sr_d <= '0;
        end else if (!or_v || out_ready) begin
            or_v <= sr_v || xin;
            or_d <= sr_v ? sr_d : (xin ? dec : '0);
            sr_v <= 1'b0;
            sr_d <= '0;
        end else if (xin) begin
            sr_v <= 1'b1;
            sr_d <= dec;
        end
    end

    assign in_ready  = !sr_v;
    assign out_valid = or_v;
    assign imm       = or_d.imm;
    assign imm_type  = or_d.ty;
    assign target    = or_d.tgt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized and directed checks of imm_gen_pipe against a queue-based model.
module tb_imm_gen_pipe;
    localparam int XLEN = 32;
`ifdef IMM_GEN_TARGET_EN
    localparam bit TGT_EN = 1'b1;
`else
    localparam bit TGT_EN = 1'b0;
`endif

    typedef struct {
        logic [XLEN-1:0] imm;
        logic [2:0]      ty;
        logic [XLEN-1:0] tgt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     inst = '0;
    logic [XLEN-1:0] pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] target;

    logic            in_valid64 = 1'b0;
    logic            in_ready64;
    logic [63:0]     pc64 = '0;
    logic            out_valid64;
    logic [63:0]     imm64;
    logic [2:0]      imm_type64;
    logic [63:0]     target64;

    int total = 0;
    int bad = 0;
    exp_t q[$];

    imm_gen_pipe #(.XLEN(XLEN), .TYPE_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .imm_type(imm_type), .target(target)
    );

    imm_gen_pipe #(.XLEN(64), .TYPE_W(3)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .inst(inst), .pc(pc64),
        .out_valid(out_valid64), .out_ready(1'b1), .imm(imm64), .imm_type(imm_type64), .target(target64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Reference: field extraction as unsigned numbers, then two's-complement correction in longint.
    function automatic exp_t model(input logic [31:0] i, input logic [XLEN-1:0] p);
        exp_t   e;
        longint v;
        int     t;
        case (i[6:2])
            5'b00000, 5'b00100, 5'b11001: begin t = 1; v = longint'(i[31:20]); if (i[31]) v -= 4096; end
            5'b01000: begin t = 2; v = longint'({i[31:25], i[11:7]}); if (i[31]) v -= 4096; end
            5'b11000: begin t = 3; v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); if (i[31]) v -= 8192; end
            5'b11011: begin t = 5; v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); if (i[31]) v -= longint'(1) << 21; end
            5'b01101, 5'b00101: begin t = 4; v = longint'({i[31:12], 12'b0}); if (i[31]) v -= longint'(1) << 32; end
            default: begin t = 0; v = 0; end
        endcase
        e.imm = v[XLEN-1:0];
        e.ty  = 3'(t);
        e.tgt = (TGT_EN && t >= 3) ? p + e.imm : '0;
        return e;
    endfunction

    // Compare current outputs to model, then drive next inputs and advance the model for the coming edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [XLEN-1:0] p, input logic r);
        bit xin, xout;
        @(negedge clk);
        if (q.size() > 0) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("imm", 64'(imm), 64'(q[0].imm));
            chk("imm_type", 64'(imm_type), 64'(q[0].ty));
            chk("target", 64'(target), 64'(q[0].tgt));
        end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
            chk("imm_idle", 64'(imm), 64'd0);
            chk("type_idle", 64'(imm_type), 64'd0);
            chk("target_idle", 64'(target), 64'd0);
        end
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        in_valid = v; inst = i; pc = p; out_ready = r;
        xin  = v && in_ready;
        xout = out_valid && r;
        if (xout && q.size() > 0) void'(q.pop_front());
        if (xin) q.push_back(model(i, p));
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t        m;
        logic [4:0]  ops [12] = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b11011,
                                  5'b01101, 5'b00101, 5'b01100, 5'b00011, 5'b11100, 5'b10100};
        logic [31:0] r;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(imm), 64'd0);
        chk("rst_type", 64'(imm_type), 64'd0);
        chk("rst_target", 64'(target), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        m = model(32'hFFF00093, '0);
        chk("model_addi_imm", 64'(m.imm), 64'hFFFFFFFF);
        chk("model_addi_type", 64'(m.ty), 64'd1);
        m = model(32'hFE000EE3, 32'h100);
        chk("model_beq_imm", 64'(m.imm), 64'hFFFFFFFC);
        chk("model_beq_tgt", 64'(m.tgt), TGT_EN ? 64'hFC : 64'h0);
        m = model(32'h0080006F, 32'hFFFFFFFC);
        chk("model_jal_tgt", 64'(m.tgt), TGT_EN ? 64'h4 : 64'h0);

        step(1'b1, 32'hFFF00093, 32'h0, 1'b1);
        after_edge();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
        chk("addi_type", 64'(imm_type), 64'd1);
        step(1'b1, 32'hFE000EE3, 32'h100, 1'b1);
        after_edge();
        chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
        chk("beq_type", 64'(imm_type), 64'd3);
        chk("beq_target", 64'(target), TGT_EN ? 64'hFC : 64'h0);
        step(1'b1, 32'h123450B7, 32'h0, 1'b1);
        after_edge();
        chk("lui_imm", 64'(imm), 64'h12345000);
        chk("lui_type", 64'(imm_type), 64'd4);
        step(1'b1, 32'h0080006F, 32'hFFFFFFFC, 1'b1);
        after_edge();
        chk("jal_imm", 64'(imm), 64'h8);
        chk("jal_type", 64'(imm_type), 64'd5);
        chk("jal_target", 64'(target), TGT_EN ? 64'h4 : 64'h0);

        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'h00500093, 32'h0, 1'b0);
        step(1'b1, 32'h00A00113, 32'h0, 1'b0);
        after_edge();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(imm), 64'd5);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        after_edge();
        chk("bp_still_a", 64'(imm), 64'd5);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        after_edge();
        chk("bp_b_next", 64'(imm), 64'd10);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1);

        step(1'b0, 32'h800000B7, 32'h0, 1'b1);
        in_valid64 = 1'b1;
        after_edge();
        in_valid64 = 1'b0;
        chk("x64_valid", 64'(out_valid64), 64'd1);
        chk("x64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("x64_type", 64'(imm_type64), 64'd4);

        for (int k = 0; k < 3000; k++) begin
            r = $urandom();
            step($urandom_range(0, 9) < 7, {r[31:7], ops[$urandom_range(0, 11)], 2'b11},
                 XLEN'($urandom()), $urandom_range(0, 9) < 6);
        end

        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'h00100093, 32'h0, 1'b0);
        step(1'b1, 32'h00200093, 32'h0, 1'b0);
        in_valid64 = 1'b1;
        @(posedge clk);
        #2;
        in_valid64 = 1'b0;
        chk("full_before_rst", 64'(in_ready), 64'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_imm", 64'(imm), 64'd0);
        chk("arst_x64_valid", 64'(out_valid64), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter TYPE_W, default 3, immediate-format code width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 SHALL have port inst  input  32  raw instruction word.
REQ-008 SHALL have port pc  input  XLEN  PC of inst.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-012 SHALL have port imm_type  output  TYPE_W  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-013 SHALL have port target  output  XLEN  pc+imm (see Configuration).

Function
REQ-014 Decode on inst[6:2]: JALR/LOAD/OP-IMM -> I; STORE -> S; BRANCH -> B; JAL -> J; LUI/AUIPC -> U; all other opcodes -> type 0, imm 0.
REQ-015 I: imm = sext(inst[31:20]); S: sext({inst[31:25],inst[11:7]}).
REQ-016 B: imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-017 U: imm = sext({inst[31:12],12'b0}) to XLEN; sign extension always from inst[31].
REQ-018 Datapath: one output register (OR) plus one skid register (SR); decode occurs before OR/SR capture.
REQ-019 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-020 in_ready SHALL equal !SR.valid (registered, no combinational path from out_ready).
REQ-021 Latency: accepted instruction appears on outputs the next cycle when OR empty or draining.
REQ-022 OR empty or draining, SR empty: transfer in loads OR.
REQ-023 OR full, not draining, transfer in: data loads SR; in_ready deasserts next cycle.
REQ-024 OR draining, SR full: SR moves to OR, SR clears; simultaneous transfer in impossible (in_ready=0).
REQ-025 Order SHALL be strict FIFO; no instruction dropped or duplicated.
REQ-026 While out_valid && !out_ready, imm, imm_type, target SHALL hold stable.
REQ-027 When out_valid=0, imm, imm_type, target SHALL be 0.

Reset
REQ-028 rst asserted: OR.valid=0, SR.valid=0, all data registers 0, immediately (asynchronous).
REQ-029 During/after reset: out_valid=0, in_ready=1, imm=0, imm_type=0, target=0; in-flight entries discarded.
REQ-030 First acceptance possible on first rising edge with rst low.

Configuration
REQ-031 Macro IMM_GEN_TARGET_EN SHALL control target computation.
REQ-032 Defined: target = pc + imm (XLEN, wrap modulo 2^XLEN) for types B, J, U; 0 otherwise; registered with imm.
REQ-033 Undefined: no adder synthesised; target tied to 0; all other behaviour identical.

Verification
REQ-034 XLEN=32, inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, imm_type=1.
REQ-035 inst=0xFE000EE3 (beq -4), pc=0x100, IMM_GEN_TARGET_EN -> imm=0xFFFFFFFC, imm_type=3, target=0x0FC; without macro target=0.
REQ-036 inst=0x123450B7 (lui) -> imm=0x12345000, type 4; inst=0x0080006F (jal +8), pc=0xFFFFFFFC -> imm=8, type 5, target=0x4 (wrap).
REQ-037 Backpressure: out_ready=0, send A then B -> in_ready=0 after B, outputs hold A; raise out_ready -> A, B emerge in order, in_ready returns 1.
REQ-038 XLEN=64, inst=0x800000B7 -> imm=0xFFFFFFFF80000000; rst pulsed mid-cycle with OR/SR full -> out_valid=0, in_ready=1 without clock edge.
